prism_aux_engine: RTL and testbench
===================================

Name: prism_aux_engine

Overview:
- Parametrised successor to the fixed PRISM peripheral's counter and shift datapath.
- Provides NUM_CNT independent counters, each configurable as a down-to-zero or an up-compare counter.
- Provides one variable-length bidirectional shift register with a bit counter, and a sticky interrupt block with per-source enables.
- Driven by PRISM FSM output strobes. Returns status bits to the FSM input vector. Configured over the TinyQV peripheral register bus.

Parameters:
- NUM_CNT, 2, number of counter channels (1..4).
- CNT_W, 24, counter, preload and compare width (8..32).
- SHIFT_W, 16, shift register width (8..32).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- exec  in  1  FSM running and not halted; all strobes are ignored when low.
- cnt_load  in  NUM_CNT  per-channel load strobe.
- cnt_step  in  NUM_CNT  per-channel decrement/increment strobe.
- shift_en  in  1  shift strobe.
- shift_in  in  1  serial input bit.
- address  in  6  register offset.
- data_in  in  32  write data.
- data_write_n  in  2  write type; only 2'b10 (32-bit) writes are accepted.
- data_out  out  32  combinational read data.
- cnt_flag  out  NUM_CNT  down mode: count==0; up mode: count==compare.
- shift_done  out  1  registered 1-cycle pulse when the bit counter wraps.
- shift_out  out  1  serial output bit.
- irq  out  1  OR of (status & enable).

Behaviour:
- Reset: all counters, preloads, compares, config, shift data, bit counter, status and enable registers = 0. irq=0, shift_done=0. cnt_flag reflects reset state (down mode, count 0 → 1).
- Register map (write takes effect the next cycle; reads are same-cycle):
  - 0x00 CFG: [3:0] mode per channel (0=down, 1=up); [8] shift_dir (0=MSB-first left shift, 1=LSB-first right shift); [20:16] shift_len-1.
  - 0x04 STATUS, W1C: [NUM_CNT-1:0] counter events; [8] shift_done event.
  - 0x08 IRQ_EN, same bit layout as STATUS.
  - 0x0C SHIFT_DATA, RW.
  - 0x20+8*i PRELOAD_i; 0x24+8*i COMPARE_i (write); reads of 0x24+8*i return the live count_i.
  - Unmapped offsets read 0.
- Counter i, when exec=1:
  - load & !step → count = preload.
  - Down mode, step & !load: decrement if count≠0; on the 1→0 transition set STATUS[i]. Saturates at 0 with no further event.
  - Up mode, step & !load: if count==compare, count = 0 and STATUS[i] is set; else count+1. All arithmetic is modulo 2^CNT_W.
  - load & step together → count = 0 (clear).
  - exec=0 → hold.
- Shift, when exec=1 & shift_en:
  - Data shifts by one, inserting shift_in: at bit 0 (dir 0) or at bit shift_len-1 (dir 1).
  - Bits at and above shift_len are forced to 0.
  - Bit counter increments; if it equals shift_len-1 it wraps to 0, pulses shift_done, and sets STATUS[8].
- shift_out: dir 0 → bit shift_len-1; dir 1 → bit 0. It is combinational from the data register.
- A shift_len-1 field > SHIFT_W-1 is clamped to SHIFT_W-1.
- A CFG write resets the bit counter to 0.
- A SHIFT_DATA write overrides a same-cycle shift.
- A bus write to a preload has no effect on the current count.
- A same-cycle hardware event set and W1C clear of one STATUS bit → the bit stays set.
- irq is registered: it asserts 1 cycle after the status set.
- rst mid-operation clears everything immediately, with no pending events.

Optional Feature:
- Macro: PRISM_AUX_CAPTURE_EN.
- Defined:
  - Adds input cnt_capture [NUM_CNT].
  - When exec & cnt_capture[i], capture_i = count_i (the value before any same-cycle update).
  - capture_i is readable at 0x40+4*i and reset to 0.
- Undefined: the port is absent and 0x40.. read 0.

Test Plan:
- Down mode: PRELOAD_0=3, load, 3 steps → count 2,1,0; STATUS[0]=1; a 4th step leaves count 0 with no new event; IRQ_EN[0]=1 → irq=1 one cycle after the status set.
- Up mode: CFG[1]=1, COMPARE_1=2 → steps give 1,2, then 0 with STATUS[1]=1; cnt_flag[1]=1 while count==2.
- Shift: shift_len=8, dir 0, shift_in pattern 1,0,1,1,0,0,1,0 → SHIFT_DATA=0xB2; shift_done pulses on the 8th shift; the next shift restarts the bit counter at 0.
- Shift: dir 1, SHIFT_DATA=0x00A5, len 8 → shift_out sequence 1,0,1,0,0,1,0,1.
- Edge cases: load&step → count 0; exec=0 with strobes → no change; W1C on the event cycle → bit remains set; rst asserted mid-count → all registers 0, irq 0.
- With PRISM_AUX_CAPTURE_EN: count_0=5, capture & step same cycle → capture_0 reads 5, count_0=4.

Source files
------------

// File: rtl/prism_aux_engine.sv
`default_nettype none
// prism_aux_engine: PRISM counter channels, variable-length shift register and sticky IRQ block.
// Build macro PRISM_AUX_CAPTURE_EN adds per-channel count capture registers at 0x40+4*i.
module prism_aux_engine #(
  parameter int NUM_CNT = 2,
  parameter int CNT_W   = 24,
  parameter int SHIFT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               exec,
  input  logic [NUM_CNT-1:0] cnt_load,
  input  logic [NUM_CNT-1:0] cnt_step,
`ifdef PRISM_AUX_CAPTURE_EN
  input  logic [NUM_CNT-1:0] cnt_capture,
  input  logic [6:0]         address,
`else
  input  logic [5:0]         address,
`endif
  input  logic               shift_en,
  input  logic               shift_in,
  input  logic [31:0]        data_in,
  input  logic [1:0]         data_write_n,
  output logic [31:0]        data_out,
  output logic [NUM_CNT-1:0] cnt_flag,
  output logic               shift_done,
  output logic               shift_out,
  output logic               irq
);

`ifdef PRISM_AUX_CAPTURE_EN
  // The capture window at 0x40 needs one offset bit beyond the base register map.
  localparam int ADDR_W = 7;
`else
  localparam int ADDR_W = 6;
`endif

  localparam logic [ADDR_W-1:0] A_CFG    = ADDR_W'(8'h00);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(8'h04);
  localparam logic [ADDR_W-1:0] A_IRQEN  = ADDR_W'(8'h08);
  localparam logic [ADDR_W-1:0] A_SDATA  = ADDR_W'(8'h0C);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [4:0]        LEN_MAX  = 5'(SHIFT_W - 1);

  logic [NUM_CNT-1:0] mode;
  logic               shift_dir;
  logic [4:0]         len_raw;
  logic [4:0]         len_m1;

  logic [NUM_CNT-1:0] cnt_status;
  logic [NUM_CNT-1:0] cnt_irq_en;
  logic [NUM_CNT-1:0] cnt_evt;
  logic [NUM_CNT-1:0] cnt_clr;
  logic               shift_status;
  logic               shift_irq_en;
  logic               shift_clr;

  logic [CNT_W-1:0]   preload [NUM_CNT];
  logic [CNT_W-1:0]   compare [NUM_CNT];
  logic [CNT_W-1:0]   count   [NUM_CNT];

  logic [SHIFT_W-1:0] shift_data;
  logic [SHIFT_W-1:0] shift_next;
  logic [SHIFT_W-1:0] shift_left;
  logic [SHIFT_W-1:0] shift_right;
  logic               shift_top;
  logic [4:0]         bit_cnt;
  logic               shift_act;
  logic               shift_wrap;

  logic               wr_en;
  logic               wr_cfg;
  logic               wr_status;
  logic               wr_irqen;
  logic               wr_sdata;
  logic               unused_bits;

  assign wr_en     = (data_write_n == 2'b10);
  assign wr_cfg    = wr_en && (address == A_CFG);
  assign wr_status = wr_en && (address == A_STATUS);
  assign wr_irqen  = wr_en && (address == A_IRQEN);
  assign wr_sdata  = wr_en && (address == A_SDATA);

  assign cnt_clr   = wr_status ? data_in[NUM_CNT-1:0] : '0;
  assign shift_clr = wr_status && data_in[8];

  assign len_m1     = (len_raw > LEN_MAX) ? LEN_MAX : len_raw;
  assign shift_act  = exec && shift_en;
  assign shift_wrap = (bit_cnt == len_m1);

  assign unused_bits = ^data_in;

  // ---------------------------------------------------------------- counters
  always_comb begin
    cnt_flag = '0;
    cnt_evt  = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      cnt_flag[i] = mode[i] ? (count[i] == compare[i]) : (count[i] == '0);
      // Down mode fires only on the 1->0 step; saturated steps at 0 stay silent.
      cnt_evt[i]  = exec && cnt_step[i] && !cnt_load[i] &&
                    (mode[i] ? (count[i] == compare[i]) : (count[i] == CNT_ONE));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        preload[i] <= '0;
        compare[i] <= '0;
        count[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (wr_en && (address == ADDR_W'(32 + 8 * i))) preload[i] <= data_in[CNT_W-1:0];
        if (wr_en && (address == ADDR_W'(36 + 8 * i))) compare[i] <= data_in[CNT_W-1:0];
        if (exec) begin
          if (cnt_load[i] && cnt_step[i]) begin
            count[i] <= '0;
          end else if (cnt_load[i]) begin
            count[i] <= preload[i];
          end else if (cnt_step[i]) begin
            if (mode[i]) begin
              count[i] <= (count[i] == compare[i]) ? '0 : count[i] + CNT_ONE;
            end else if (count[i] != '0) begin
              count[i] <= count[i] - CNT_ONE;
            end
          end
        end
      end
    end
  end

`ifdef PRISM_AUX_CAPTURE_EN
  logic [CNT_W-1:0] capture [NUM_CNT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CNT; i++) capture[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (exec && cnt_capture[i]) capture[i] <= count[i];
      end
    end
  end
`endif

  // ----------------------------------------------------------- shift register
  assign shift_left  = {shift_data[SHIFT_W-2:0], shift_in};
  assign shift_right = shift_data >> 1;

  always_comb begin
    shift_next = '0;
    shift_top  = 1'b0;
    for (int b = 0; b < SHIFT_W; b++) begin
      if (5'(b) == len_m1) shift_top = shift_data[b];
      if (5'(b) <= len_m1) begin
        if (shift_dir) shift_next[b] = (5'(b) == len_m1) ? shift_in : shift_right[b];
        else           shift_next[b] = shift_left[b];
      end
    end
  end

  assign shift_out = shift_dir ? shift_data[0] : shift_top;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_data <= '0;
      bit_cnt    <= '0;
      shift_done <= 1'b0;
    end else begin
      if (wr_sdata)       shift_data <= data_in[SHIFT_W-1:0];
      else if (shift_act) shift_data <= shift_next;

      if (wr_cfg)         bit_cnt <= '0;
      else if (shift_act) bit_cnt <= shift_wrap ? 5'd0 : bit_cnt + 5'd1;

      shift_done <= shift_act && shift_wrap;
    end
  end

  // ------------------------------------------------ config, status and IRQ
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode         <= '0;
      shift_dir    <= 1'b0;
      len_raw      <= '0;
      cnt_irq_en   <= '0;
      shift_irq_en <= 1'b0;
      cnt_status   <= '0;
      shift_status <= 1'b0;
      irq          <= 1'b0;
    end else begin
      if (wr_cfg) begin
        mode      <= data_in[NUM_CNT-1:0];
        shift_dir <= data_in[8];
        len_raw   <= data_in[20:16];
      end
      if (wr_irqen) begin
        cnt_irq_en   <= data_in[NUM_CNT-1:0];
        shift_irq_en <= data_in[8];
      end
      // A hardware set wins over a same-cycle W1C.
      cnt_status   <= (cnt_status & ~cnt_clr) | cnt_evt;
      shift_status <= (shift_status && !shift_clr) || (shift_act && shift_wrap);
      irq          <= (|(cnt_status & cnt_irq_en)) || (shift_status && shift_irq_en);
    end
  end

  // --------------------------------------------------------------- read mux
  always_comb begin
    data_out = 32'd0;
    if (address == A_CFG) begin
      data_out[NUM_CNT-1:0] = mode;
      data_out[8]           = shift_dir;
      data_out[20:16]       = len_raw;
    end
    if (address == A_STATUS) begin
      data_out[NUM_CNT-1:0] = cnt_status;
      data_out[8]           = shift_status;
    end
    if (address == A_IRQEN) begin
      data_out[NUM_CNT-1:0] = cnt_irq_en;
      data_out[8]           = shift_irq_en;
    end
    if (address == A_SDATA) data_out[SHIFT_W-1:0] = shift_data;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (address == ADDR_W'(32 + 8 * i)) data_out[CNT_W-1:0] = preload[i];
      if (address == ADDR_W'(36 + 8 * i)) data_out[CNT_W-1:0] = count[i];
`ifdef PRISM_AUX_CAPTURE_EN
      if (address == ADDR_W'(64 + 4 * i)) data_out[CNT_W-1:0] = capture[i];
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prism_aux_engine.sv
`default_nettype none
// tb_prism_aux_engine: scoreboard bench for the PRISM counter/shift/IRQ engine.
module tb_prism_aux_engine;

  localparam int NUM_CNT = 2;
  localparam int CNT_W   = 24;
  localparam int SHIFT_W = 16;
`ifdef PRISM_AUX_CAPTURE_EN
  localparam int ADDR_W = 7;
`else
  localparam int ADDR_W = 6;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               exec = 1'b0;
  logic [NUM_CNT-1:0] cnt_load = '0;
  logic [NUM_CNT-1:0] cnt_step = '0;
  logic               shift_en = 1'b0;
  logic               shift_in = 1'b0;
  logic [ADDR_W-1:0]  address = '0;
  logic [31:0]        data_in = '0;
  logic [1:0]         data_write_n = 2'b11;
  logic [31:0]        data_out;
  logic [NUM_CNT-1:0] cnt_flag;
  logic               shift_done;
  logic               shift_out;
  logic               irq;
`ifdef PRISM_AUX_CAPTURE_EN
  logic [NUM_CNT-1:0] cnt_capture = '0;
`endif

  prism_aux_engine #(.NUM_CNT(NUM_CNT), .CNT_W(CNT_W), .SHIFT_W(SHIFT_W)) dut (
    .clk(clk), .rst(rst), .exec(exec),
    .cnt_load(cnt_load), .cnt_step(cnt_step),
`ifdef PRISM_AUX_CAPTURE_EN
    .cnt_capture(cnt_capture),
`endif
    .address(address), .shift_en(shift_en), .shift_in(shift_in),
    .data_in(data_in), .data_write_n(data_write_n), .data_out(data_out),
    .cnt_flag(cnt_flag), .shift_done(shift_done), .shift_out(shift_out), .irq(irq)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got;
  logic [31:0] exp;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input int a, input logic [31:0] d);
    address = ADDR_W'(a);
    data_in = d;
    data_write_n = 2'b10;
    tick();
    data_write_n = 2'b11;
    data_in = '0;
  endtask

  task automatic bus_rd(input int a, output logic [31:0] d);
    address = ADDR_W'(a);
    #1;
    d = data_out;
  endtask

  task automatic strobe(input logic [NUM_CNT-1:0] ld, input logic [NUM_CNT-1:0] st,
                        input logic sh, input logic si);
    cnt_load = ld; cnt_step = st; shift_en = sh; shift_in = si;
    tick();
    cnt_load = '0; cnt_step = '0; shift_en = 1'b0; shift_in = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    exp_q.push_back(32'd0); bus_rd('h00, got); exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL reset_cfg: got %0h want %0h", got, exp); end
    exp_q.push_back(32'd0); bus_rd('h04, got); exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL reset_status: got %0h want %0h", got, exp); end
    exp_q.push_back(32'd0); bus_rd('h24, got); exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL reset_count0: got %0h want %0h", got, exp); end
    exp_q.push_back(32'h3); got = {30'd0, cnt_flag}; exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL reset_flag: got %0h want %0h", got, exp); end
    exp_q.push_back(32'd0); got = {30'd0, shift_done, irq}; exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL reset_done_irq: got %0h want %0h", got, exp); end
  endtask

  task automatic test_down();
    exec = 1'b1;
    bus_wr('h08, 32'h1);
    bus_wr('h20, 32'd3);
    exp_q.push_back(32'd0); bus_rd('h24, got); exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL preload_no_effect: got %0h want %0h", got, exp); end
    strobe(2'b01, 2'b00, 1'b0, 1'b0);
    exp_q.push_back(32'd3); bus_rd('h24, got); exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL down_load: got %0h want %0h", got, exp); end
    for (int j = 0; j < 3; j++) begin
      exp_q.push_back(32'(2 - j));
      strobe(2'b00, 2'b01, 1'b0, 1'b0);
      bus_rd('h24, got); exp = exp_q.pop_front(); vectors++;
      if (got !== exp) begin miscompares++; $display("FAIL down_step%0d: got %0h want %0h", j, got, exp); end
    end
    exp_q.push_back(32'h1); bus_rd('h04, got); exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL down_status: got %0h want %0h", got, exp); end
    exp_q.push_back(32'h0); got = {31'd0, irq}; exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL irq_early: got %0h want %0h", got, exp); end
    tick();
    exp_q.push_back(32'h1); got = {31'd0, irq}; exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL irq_late: got %0h want %0h", got, exp); end
    bus_wr('h04, 32'h1);
    strobe(2'b00, 2'b01, 1'b0, 1'b0);
    exp_q.push_back(32'd0); bus_rd('h24, got); exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL down_saturate: got %0h want %0h", got, exp); end
    exp_q.push_back(32'd0); bus_rd('h04, got); exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL down_no_event: got %0h want %0h", got, exp); end
    bus_wr('h08, 32'h0);
  endtask

  task automatic test_up();
    bus_wr('h00, 32'h2);
    bus_wr('h2C, 32'd2);
    for (int j = 0; j < 3; j++) begin
      exp_q.push_back((j == 2) ? 32'd0 : 32'(j + 1));
      exp_q.push_back((j == 1) ? 32'd1 : 32'd0);
      strobe(2'b00, 2'b10, 1'b0, 1'b0);
      bus_rd('h2C, got); exp = exp_q.pop_front(); vectors++;
      if (got !== exp) begin miscompares++; $display("FAIL up_count%0d: got %0h want %0h", j, got, exp); end
      got = {31'd0, cnt_flag[1]}; exp = exp_q.pop_front(); vectors++;
      if (got !== exp) begin miscompares++; $display("FAIL up_flag%0d: got %0h want %0h", j, got, exp); end
    end
    exp_q.push_back(32'h2); bus_rd('h04, got); exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL up_status: got %0h want %0h", got, exp); end
    bus_wr('h04, 32'h2);
  endtask

  task automatic test_shift_left();
    int pat[8] = '{1, 0, 1, 1, 0, 0, 1, 0};
    logic [7:0] md = 8'd0;
    int hits = 0;
    int last = -1;
    bus_wr('h00, 32'h0007_0002);
    bus_wr('h0C, 32'h0);
    for (int j = 0; j < 8; j++) begin
      md = {md[6:0], pat[j][0]};
      exp_q.push_back((j == 7) ? 32'd1 : 32'd0);
      strobe(2'b00, 2'b00, 1'b1, pat[j][0]);
      got = {31'd0, shift_done}; exp = exp_q.pop_front(); vectors++;
      if (got !== exp) begin miscompares++; $display("FAIL shl_done%0d: got %0h want %0h", j, got, exp); end
    end
    exp_q.push_back({24'd0, md}); bus_rd('h0C, got); exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL shl_data: got %0h want %0h", got, exp); end
    exp_q.push_back(32'h100); bus_rd('h04, got); exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL shl_status: got %0h want %0h", got, exp); end
    exp_q.push_back({16'd1, 16'd7});
    for (int j = 0; j < 8; j++) begin
      strobe(2'b00, 2'b00, 1'b1, 1'b0);
      if (shift_done) begin hits++; last = j; end
    end
    got = {16'(hits), 16'(last)}; exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL shl_restart: got %0h want %0h", got, exp); end
    bus_wr('h04, 32'h100);
  endtask

  task automatic test_shift_right();
    int seq[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    bus_wr('h00, 32'h0007_0102);
    bus_wr('h0C, 32'h00A5);
    for (int j = 0; j < 8; j++) exp_q.push_back(32'(seq[j]));
    for (int j = 0; j < 8; j++) begin
      got = {31'd0, shift_out}; exp = exp_q.pop_front(); vectors++;
      if (got !== exp) begin miscompares++; $display("FAIL shr_out%0d: got %0h want %0h", j, got, exp); end
      strobe(2'b00, 2'b00, 1'b1, 1'b0);
    end
    bus_wr('h04, 32'h100);
  endtask

  task automatic test_edges();
    bus_wr('h00, 32'h2);
    bus_wr('h20, 32'd9);
    strobe(2'b01, 2'b00, 1'b0, 1'b0);
    strobe(2'b01, 2'b01, 1'b0, 1'b0);
    exp_q.push_back(32'd0); bus_rd('h24, got); exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL load_step_clear: got %0h want %0h", got, exp); end
    strobe(2'b01, 2'b00, 1'b0, 1'b0);
    bus_wr('h0C, 32'h5);
    exec = 1'b0;
    strobe(2'b11, 2'b11, 1'b1, 1'b1);
    exec = 1'b1;
    exp_q.push_back(32'd9); bus_rd('h24, got); exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL exec0_count: got %0h want %0h", got, exp); end
    exp_q.push_back(32'h5); bus_rd('h0C, got); exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL exec0_shift: got %0h want %0h", got, exp); end
    address = ADDR_W'('h0C); data_in = 32'hFF; data_write_n = 2'b00;
    tick();
    data_write_n = 2'b11; data_in = '0;
    exp_q.push_back(32'h5); bus_rd('h0C, got); exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL write_type: got %0h want %0h", got, exp); end
    bus_wr('h20, 32'd1);
    strobe(2'b01, 2'b00, 1'b0, 1'b0);
    address = ADDR_W'('h04); data_in = 32'h1; data_write_n = 2'b10; cnt_step = 2'b01;
    tick();
    data_write_n = 2'b11; data_in = '0; cnt_step = '0;
    exp_q.push_back(32'h1); bus_rd('h04, got); exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL w1c_vs_set: got %0h want %0h", got, exp); end
    exp_q.push_back(32'h0); bus_rd('h30, got); exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL unmapped: got %0h want %0h", got, exp); end
    bus_wr('h00, 32'h001F_0002);
    bus_wr('h0C, 32'h8000);
    exp_q.push_back(32'h1); got = {31'd0, shift_out}; exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL len_clamp: got %0h want %0h", got, exp); end
  endtask

  task automatic test_reset_mid();
    bus_wr('h08, 32'h1);
    tick();
    exp_q.push_back(32'h1); got = {31'd0, irq}; exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL pre_rst_irq: got %0h want %0h", got, exp); end
    bus_wr('h20, 32'd7);
    strobe(2'b01, 2'b00, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    exp_q.push_back(32'h0); got = {30'd0, shift_done, irq}; exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL rst_irq: got %0h want %0h", got, exp); end
    exp_q.push_back(32'h0); bus_rd('h24, got); exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL rst_count: got %0h want %0h", got, exp); end
    exp_q.push_back(32'h0); bus_rd('h04, got); exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL rst_status: got %0h want %0h", got, exp); end
    exp_q.push_back(32'h0); bus_rd('h0C, got); exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL rst_sdata: got %0h want %0h", got, exp); end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

`ifdef PRISM_AUX_CAPTURE_EN
  task automatic test_capture();
    bus_wr('h20, 32'd5);
    strobe(2'b01, 2'b00, 1'b0, 1'b0);
    cnt_capture = 2'b01; cnt_step = 2'b01;
    tick();
    cnt_capture = '0; cnt_step = '0;
    exp_q.push_back(32'd5); bus_rd('h40, got); exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL capture_val: got %0h want %0h", got, exp); end
    exp_q.push_back(32'd4); bus_rd('h24, got); exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL capture_count: got %0h want %0h", got, exp); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_down();
    test_up();
    test_shift_left();
    test_shift_right();
    test_edges();
    test_reset_mid();
`ifdef PRISM_AUX_CAPTURE_EN
    test_capture();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
